// File: rtl/spi_eeprom_pkg.sv
// Shared definitions for the 25xx-style SPI EEPROM responder and its bus-side bridge.
package spi_eeprom_pkg;

    localparam logic [7:0] SPI_CMD_WRSR  = 8'h01;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRDI  = 8'h04;
    localparam logic [7:0] SPI_CMD_RDSR  = 8'h05;
    localparam logic [7:0] SPI_CMD_WREN  = 8'h06;

    localparam int unsigned STAT_WIP = 0;
    localparam int unsigned STAT_WEL = 1;
    localparam int unsigned STAT_BP0 = 2;
    localparam int unsigned STAT_BP1 = 3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR_HI,
        S_ADDR_LO,
        S_READ_DATA,
        S_WRITE_DATA,
        S_RDSR_OUT,
        S_WRSR_IN,
        S_IGNORE
    } state_e;

    // top2 is the two most significant implemented address bits
    function automatic logic bp_protects(input logic [1:0] bp, input logic [1:0] top2);
        case (bp)
            2'b00:   return 1'b0;
            2'b01:   return top2 == 2'b11;
            2'b10:   return top2[1];
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/spi_eeprom_responder_if.sv
// SPI pin bundle between a bus-side master and the EEPROM responder.
interface spi_eeprom_responder_if;
    logic SPI_SCK;
    logic SPI_CS;
    logic SPI_MOSI;
    logic SPI_MISO;
    logic SPI_MISO_OE;

    modport master (output SPI_SCK, SPI_CS, SPI_MOSI, input SPI_MISO, SPI_MISO_OE);
    modport slave  (input SPI_SCK, SPI_CS, SPI_MOSI, output SPI_MISO, SPI_MISO_OE);
endinterface

// File: rtl/spi_slave_shifter.sv
// Oversampled SPI slave front end: pin synchronisers, SCK edge detect, byte assembly and MISO shifting.
module spi_slave_shifter (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sck_i,
    input  logic       cs_i,
    input  logic       mosi_i,
    input  logic       load_req_i,
    input  logic [7:0] load_byte_i,
    output logic       byte_valid_o,
    output logic [7:0] rx_byte_o,
    output logic       cs_high_o,
    output logic       cs_rise_o,
    output logic       miso_o
);
    logic [2:0] sck_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;
    logic [2:0] cnt_q;
    logic [6:0] rx_q;
    logic [7:0] tx_q;
    logic       sck_rise;
    logic       sck_fall;

    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] & sck_q[2];
    assign cs_high_o = cs_q[1];
    assign cs_rise_o = cs_q[1] & ~cs_q[2];

    // CS high masks any simultaneous SCK edge, so a late edge never completes a byte
    assign byte_valid_o = sck_rise & ~cs_q[1] & (cnt_q == 3'd7);
    assign rx_byte_o    = {rx_q, mosi_q[1]};
    assign miso_o       = tx_q[7];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_q  <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
            cnt_q  <= '0;
            rx_q   <= '0;
            tx_q   <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], sck_i};
            cs_q   <= {cs_q[1:0], cs_i};
            mosi_q <= {mosi_q[0], mosi_i};
            if (cs_q[1]) begin
                cnt_q <= '0;
                rx_q  <= '0;
                tx_q  <= '0;
            end else begin
                if (sck_rise) begin
                    cnt_q <= cnt_q + 3'd1;
                    rx_q  <= {rx_q[5:0], mosi_q[1]};
                end
                // a falling edge at bit count 0 is the start of a new outgoing byte
                if (sck_fall) begin
                    tx_q <= (load_req_i && cnt_q == 3'd0) ? load_byte_i : {tx_q[6:0], 1'b0};
                end
            end
        end
    end
endmodule

// File: rtl/spi_eeprom_responder.sv
// 25xx-series serial EEPROM model: command FSM, status register with block protect, byte array.
module spi_eeprom_responder
    import spi_eeprom_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned PAGE_SIZE = 16,
    parameter logic [7:0]  INIT_BYTE = 8'hFF
) (
    input  logic                     bus2ip_clk,
    input  logic                     rst_n,
    spi_eeprom_responder_if.slave    spi,
    output logic [7:0]               status_reg,
    output logic                     cmd_done,
    output logic [7:0]               last_cmd
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned PW    = $clog2(PAGE_SIZE);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          cmd_q, cmd_d;
    logic                rec_q, rec_d;
    logic                seen_q, seen_d;
    logic                wel_q, wel_d;
    logic [1:0]          bp_q, bp_d;
    logic [7:0]          last_cmd_q, last_cmd_d;
    logic                cmd_done_q, cmd_done_d;
    logic [7:0]          mem_q [DEPTH];
    logic                mem_we;
    logic                byte_valid, cs_high, cs_rise, load_req;
    logic [7:0]          rx_byte, load_byte;

    assign load_req  = (state_q == S_READ_DATA) || (state_q == S_RDSR_OUT);
    assign load_byte = (state_q == S_RDSR_OUT) ? status_reg : mem_q[addr_q];
    assign spi.SPI_MISO_OE = load_req;
    assign cmd_done  = cmd_done_q;
    assign last_cmd  = last_cmd_q;

    spi_slave_shifter u_shifter (
        .clk_i        (bus2ip_clk),
        .rst_ni       (rst_n),
        .sck_i        (spi.SPI_SCK),
        .cs_i         (spi.SPI_CS),
        .mosi_i       (spi.SPI_MOSI),
        .load_req_i   (load_req),
        .load_byte_i  (load_byte),
        .byte_valid_o (byte_valid),
        .rx_byte_o    (rx_byte),
        .cs_high_o    (cs_high),
        .cs_rise_o    (cs_rise),
        .miso_o       (spi.SPI_MISO)
    );

    always_comb begin
        status_reg                    = '0;
        status_reg[STAT_BP1:STAT_BP0] = bp_q;
        status_reg[STAT_WEL]          = wel_q;
        status_reg[STAT_WIP]          = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cmd_d      = cmd_q;
        rec_d      = rec_q;
        seen_d     = seen_q;
        wel_d      = wel_q;
        bp_d       = bp_q;
        last_cmd_d = last_cmd_q;
        cmd_done_d = 1'b0;
        mem_we     = 1'b0;
        if (cs_rise && rec_q) begin
            cmd_done_d = 1'b1;
            last_cmd_d = cmd_q;
            if ((cmd_q == SPI_CMD_WRITE || cmd_q == SPI_CMD_WRSR) && seen_q) wel_d = 1'b0;
        end
        if (cs_high) begin
            state_d = S_IDLE;
            rec_d   = 1'b0;
            seen_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_CMD;
                S_CMD: if (byte_valid) begin
                    cmd_d = rx_byte;
                    rec_d = 1'b1;
                    case (rx_byte)
                        SPI_CMD_READ, SPI_CMD_WRITE: state_d = S_ADDR_HI;
                        SPI_CMD_RDSR: state_d = S_RDSR_OUT;
                        SPI_CMD_WRSR: state_d = S_WRSR_IN;
                        SPI_CMD_WREN: begin wel_d = 1'b1; state_d = S_IGNORE; end
                        SPI_CMD_WRDI: begin wel_d = 1'b0; state_d = S_IGNORE; end
                        default:      begin rec_d = 1'b0; state_d = S_IGNORE; end
                    endcase
                end
                S_ADDR_HI: if (byte_valid) begin
                    addr_d  = ADDR_W'(rx_byte);
                    state_d = S_ADDR_LO;
                end
                // upper received address bits fall off the top here
                S_ADDR_LO: if (byte_valid) begin
                    addr_d  = ADDR_W'({addr_q, rx_byte});
                    state_d = (cmd_q == SPI_CMD_READ) ? S_READ_DATA : S_WRITE_DATA;
                end
                S_READ_DATA: if (byte_valid) addr_d = addr_q + ADDR_W'(1);
                S_WRITE_DATA: if (byte_valid) begin
                    seen_d         = 1'b1;
                    mem_we         = wel_q && !bp_protects(bp_q, addr_q[ADDR_W-1 -: 2]);
                    addr_d[PW-1:0] = addr_q[PW-1:0] + PW'(1);
                end
                S_WRSR_IN: if (byte_valid && !seen_q) begin
                    seen_d = 1'b1;
                    if (wel_q) bp_d = rx_byte[3:2];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge bus2ip_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cmd_q      <= '0;
            rec_q      <= 1'b0;
            seen_q     <= 1'b0;
            wel_q      <= 1'b0;
            bp_q       <= '0;
            last_cmd_q <= '0;
            cmd_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cmd_q      <= cmd_d;
            rec_q      <= rec_d;
            seen_q     <= seen_d;
            wel_q      <= wel_d;
            bp_q       <= bp_d;
            last_cmd_q <= last_cmd_d;
            cmd_done_q <= cmd_done_d;
        end
    end

    always_ff @(posedge bus2ip_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= INIT_BYTE;
        end else if (mem_we) begin
            mem_q[addr_q] <= rx_byte;
        end
    end
endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Directed bench for spi_eeprom_responder: SPI transaction vector table plus reset and partial-byte sequences.
module tb_spi_eeprom_responder;

    typedef struct packed {
        logic        m3;
        logic [3:0]  nb;
        logic [63:0] tx;
        logic [7:0]  chk;
        logic [63:0] exp;
        logic [7:0]  oe;
        logic [7:0]  last;
        logic [1:0]  done;
        logic [7:0]  st;
    } vec_t;

    localparam int H  = 5;
    localparam int NV = 31;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] status, last_cmd;
    logic       cmd_done;
    logic [7:0] txb [8];
    logic [7:0] rxb [8];
    logic       oes [8];
    int         n_chk = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    vec_t       vecs [NV];

    spi_eeprom_responder_if bus ();

    spi_eeprom_responder #(.ADDR_W(8), .PAGE_SIZE(16), .INIT_BYTE(8'hFF)) dut (
        .bus2ip_clk (clk),
        .rst_n      (rst_n),
        .spi        (bus),
        .status_reg (status),
        .cmd_done   (cmd_done),
        .last_cmd   (last_cmd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cmd_done) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mkv(input logic m3, input logic [3:0] nb, input logic [63:0] tx,
                                 input logic [7:0] chk, input logic [63:0] exp, input logic [7:0] oe,
                                 input logic [7:0] last, input logic [1:0] done, input logic [7:0] st);
        vec_t r;
        r.m3 = m3; r.nb = nb; r.tx = tx; r.chk = chk; r.exp = exp;
        r.oe = oe; r.last = last; r.done = done; r.st = st;
        return r;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic xfer(input int nbits, input logic m3, input logic hold);
        int i;
        int b;
        for (int k = 0; k < 8; k++) begin rxb[k] = '0; oes[k] = 1'b0; end
        if (m3) begin bus.SPI_SCK = 1'b1; repeat (H) @(negedge clk); end
        bus.SPI_CS = 1'b0;
        repeat (H) @(negedge clk);
        for (int k = 0; k < nbits; k++) begin
            i = k / 8;
            b = 7 - (k % 8);
            bus.SPI_SCK  = 1'b0;
            bus.SPI_MOSI = txb[i][b];
            repeat (H) @(negedge clk);
            if (b == 7) oes[i] = bus.SPI_MISO_OE;
            rxb[i] = {rxb[i][6:0], bus.SPI_MISO};
            bus.SPI_SCK = 1'b1;
            repeat (H) @(negedge clk);
        end
        if (!hold) begin
            if (!m3) bus.SPI_SCK = 1'b0;
            repeat (H) @(negedge clk);
            bus.SPI_CS = 1'b1;
            repeat (8) @(negedge clk);
            bus.SPI_SCK = 1'b0;
            repeat (H) @(negedge clk);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int d0;
        int n;
        int j;
        n = int'(v.nb);
        for (int i = 0; i < 8; i++) txb[i] = 8'h00;
        for (int i = 0; i < n; i++) txb[i] = v.tx[8*(n-1-i) +: 8];
        d0 = done_cnt;
        xfer(8 * n, v.m3, 1'b0);
        for (int i = 0; i < n; i++) begin
            j = n - 1 - i;
            if (v.chk[j]) check($sformatf("v%0d miso byte%0d", idx, i), rxb[i], v.exp[8*j +: 8]);
            check($sformatf("v%0d oe byte%0d", idx, i), {7'b0, oes[i]}, {7'b0, v.oe[j]});
        end
        check($sformatf("v%0d last_cmd", idx), last_cmd, v.last);
        check($sformatf("v%0d status", idx), status, v.st);
        check($sformatf("v%0d cmd_done pulses", idx), 8'(done_cnt - d0), {6'b0, v.done});
        check($sformatf("v%0d idle oe/miso", idx), {6'b0, bus.SPI_MISO_OE, bus.SPI_MISO}, 8'h00);
    endtask

    initial begin
        int d0;
        vecs[0]  = mkv(1'b0, 4'd4, 64'h03008000,     8'b0001,   64'hFF,     8'b0001,   8'h03, 2'd1, 8'h00);
        vecs[1]  = mkv(1'b0, 4'd1, 64'h06,           8'h00,     64'h0,      8'h00,     8'h06, 2'd1, 8'h02);
        vecs[2]  = mkv(1'b0, 4'd5, 64'h020010A53C,   8'h00,     64'h0,      8'h00,     8'h02, 2'd1, 8'h00);
        vecs[3]  = mkv(1'b0, 4'd6, 64'h030010000000, 8'b000111, 64'hA53CFF, 8'b000111, 8'h03, 2'd1, 8'h00);
        vecs[4]  = mkv(1'b0, 4'd4, 64'h02002011,     8'h00,     64'h0,      8'h00,     8'h02, 2'd1, 8'h00);
        vecs[5]  = mkv(1'b0, 4'd4, 64'h03002000,     8'b0001,   64'hFF,     8'b0001,   8'h03, 2'd1, 8'h00);
        vecs[6]  = mkv(1'b0, 4'd1, 64'h06,           8'h00,     64'h0,      8'h00,     8'h06, 2'd1, 8'h02);
        vecs[7]  = mkv(1'b0, 4'd7, 64'h02001E01020304, 8'h00,   64'h0,      8'h00,     8'h02, 2'd1, 8'h00);
        vecs[8]  = mkv(1'b1, 4'd5, 64'h0300100000,   8'b00011,  64'h0304,   8'b00011,  8'h03, 2'd1, 8'h00);
        vecs[9]  = mkv(1'b0, 4'd6, 64'h03001E000000, 8'b000111, 64'h0102FF, 8'b000111, 8'h03, 2'd1, 8'h00);
        vecs[10] = mkv(1'b0, 4'd1, 64'h06,           8'h00,     64'h0,      8'h00,     8'h06, 2'd1, 8'h02);
        vecs[11] = mkv(1'b0, 4'd4, 64'h0200FF77,     8'h00,     64'h0,      8'h00,     8'h02, 2'd1, 8'h00);
        vecs[12] = mkv(1'b0, 4'd1, 64'h06,           8'h00,     64'h0,      8'h00,     8'h06, 2'd1, 8'h02);
        vecs[13] = mkv(1'b0, 4'd2, 64'h010C,         8'h00,     64'h0,      8'h00,     8'h01, 2'd1, 8'h0C);
        vecs[14] = mkv(1'b1, 4'd3, 64'h050000,       8'b011,    64'h0C0C,   8'b011,    8'h05, 2'd1, 8'h0C);
        vecs[15] = mkv(1'b0, 4'd1, 64'h06,           8'h00,     64'h0,      8'h00,     8'h06, 2'd1, 8'h0E);
        vecs[16] = mkv(1'b0, 4'd2, 64'h0500,         8'b01,     64'h0E,     8'b01,     8'h05, 2'd1, 8'h0E);
        vecs[17] = mkv(1'b0, 4'd4, 64'h02000055,     8'h00,     64'h0,      8'h00,     8'h02, 2'd1, 8'h0C);
        vecs[18] = mkv(1'b0, 4'd5, 64'h0300FF0000,   8'b00011,  64'h77FF,   8'b00011,  8'h03, 2'd1, 8'h0C);
        vecs[19] = mkv(1'b0, 4'd4, 64'h03121000,     8'b0001,   64'h03,     8'b0001,   8'h03, 2'd1, 8'h0C);
        vecs[20] = mkv(1'b0, 4'd1, 64'h06,           8'h00,     64'h0,      8'h00,     8'h06, 2'd1, 8'h0E);
        vecs[21] = mkv(1'b0, 4'd1, 64'h04,           8'h00,     64'h0,      8'h00,     8'h04, 2'd1, 8'h0C);
        vecs[22] = mkv(1'b0, 4'd2, 64'h9F00,         8'h00,     64'h0,      8'h00,     8'h04, 2'd0, 8'h0C);
        vecs[23] = mkv(1'b0, 4'd2, 64'h0100,         8'h00,     64'h0,      8'h00,     8'h01, 2'd1, 8'h0C);
        vecs[24] = mkv(1'b0, 4'd1, 64'h06,           8'h00,     64'h0,      8'h00,     8'h06, 2'd1, 8'h0E);
        vecs[25] = mkv(1'b0, 4'd2, 64'h0104,         8'h00,     64'h0,      8'h00,     8'h01, 2'd1, 8'h04);
        vecs[26] = mkv(1'b0, 4'd1, 64'h06,           8'h00,     64'h0,      8'h00,     8'h06, 2'd1, 8'h06);
        vecs[27] = mkv(1'b0, 4'd4, 64'h0200C0AA,     8'h00,     64'h0,      8'h00,     8'h02, 2'd1, 8'h04);
        vecs[28] = mkv(1'b0, 4'd1, 64'h06,           8'h00,     64'h0,      8'h00,     8'h06, 2'd1, 8'h06);
        vecs[29] = mkv(1'b0, 4'd4, 64'h0200BF5A,     8'h00,     64'h0,      8'h00,     8'h02, 2'd1, 8'h04);
        vecs[30] = mkv(1'b0, 4'd5, 64'h0300BF0000,   8'b00011,  64'h5AFF,   8'b00011,  8'h03, 2'd1, 8'h04);

        bus.SPI_SCK  = 1'b0;
        bus.SPI_CS   = 1'b1;
        bus.SPI_MOSI = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        check("reset status", status, 8'h00);
        check("reset last_cmd", last_cmd, 8'h00);
        check("reset miso/oe/done", {5'b0, cmd_done, bus.SPI_MISO_OE, bus.SPI_MISO}, 8'h00);
        check("reset done count", 8'(done_cnt), 8'h00);

        for (int k = 0; k < NV; k++) run_vec(k, vecs[k]);

        // reset pulsed partway through the high address byte of a READ
        txb[0] = 8'h03; txb[1] = 8'h00; txb[2] = 8'h10;
        d0 = done_cnt;
        xfer(12, 1'b0, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst status", status, 8'h00);
        check("midrst last_cmd", last_cmd, 8'h00);
        check("midrst miso/oe/done", {5'b0, cmd_done, bus.SPI_MISO_OE, bus.SPI_MISO}, 8'h00);
        bus.SPI_CS  = 1'b1;
        bus.SPI_SCK = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst no cmd_done", 8'(done_cnt - d0), 8'h00);
        run_vec(100, mkv(1'b0, 4'd4, 64'h03001000, 8'b0001, 64'hFF, 8'b0001, 8'h03, 2'd1, 8'h00));
        run_vec(101, mkv(1'b0, 4'd4, 64'h0300BF00, 8'b0001, 64'hFF, 8'b0001, 8'h03, 2'd1, 8'h00));
        run_vec(102, mkv(1'b0, 4'd5, 64'h0300FF0000, 8'b00011, 64'hFFFF, 8'b00011, 8'h03, 2'd1, 8'h00));

        // WRITE cut off after half a data byte: nothing written, WEL kept
        run_vec(103, mkv(1'b0, 4'd1, 64'h06, 8'h00, 64'h0, 8'h00, 8'h06, 2'd1, 8'h02));
        txb[0] = 8'h02; txb[1] = 8'h00; txb[2] = 8'h30; txb[3] = 8'h00;
        d0 = done_cnt;
        xfer(28, 1'b0, 1'b0);
        check("partial last_cmd", last_cmd, 8'h02);
        check("partial status keeps WEL", status, 8'h02);
        check("partial cmd_done pulses", 8'(done_cnt - d0), 8'h01);
        run_vec(104, mkv(1'b0, 4'd4, 64'h03003000, 8'b0001, 64'hFF, 8'b0001, 8'h03, 2'd1, 8'h02));
        run_vec(105, mkv(1'b0, 4'd4, 64'h020030C3, 8'h00, 64'h0, 8'h00, 8'h02, 2'd1, 8'h00));
        run_vec(106, mkv(1'b1, 4'd4, 64'h03003000, 8'b0001, 64'hC3, 8'b0001, 8'h03, 2'd1, 8'h00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_eeprom_responder.md
Name: spi_eeprom_responder

Overview:
- SPI slave modelling a 25xx-series serial EEPROM; the far end of the AXI-Lite-to-SPI bridge.
- Decodes READ/WRITE/WRDI/WREN/RDSR/WRSR from the bus master against an internal byte array.
- Used as the in-fabric loopback target and simulation partner for the bridge.
- SPI pins are oversampled in the bus2ip_clk domain; nothing is clocked by SPI_SCK.

Parameters:
- ADDR_W, 8, implemented address bits. Memory is 2**ADDR_W bytes; upper received address bits are ignored.
- PAGE_SIZE, 16, write page size in bytes (power of two). Write addresses wrap inside the page.
- INIT_BYTE, 8'hFF, content of every memory byte after reset.

Ports:
- bus2ip_clk  in  1  system clock (16 MHz)
- rst_n  in  1  asynchronous, active-low reset
- SPI_SCK  in  1  serial clock from master, mode 0 or mode 3, at most bus2ip_clk/8
- SPI_CS  in  1  chip select, active low
- SPI_MOSI  in  1  master-out data, MSB first
- SPI_MISO  out  1  slave-out data, MSB first
- SPI_MISO_OE  out  1  high while a READ or RDSR data phase is active
- status_reg  out  8  {4'b0, BP[1:0], WEL, WIP=0}
- cmd_done  out  1  one-cycle pulse on CS deassertion after any recognised opcode
- last_cmd  out  8  opcode of the most recent recognised command

Behaviour:
- Reset (async, rst_n=0): state IDLE; SPI_MISO=0, SPI_MISO_OE=0, status_reg=0, cmd_done=0, last_cmd=0; memory filled with INIT_BYTE.
- Input conditioning: SCK, CS and MOSI each pass through a 2-FF synchroniser. A third register on SCK provides edge detection. Latency from pin to action is at most 3 clocks.
- MOSI is sampled on the synchronised SCK rising edge. MISO is updated on the falling edge, which gives identical logic for modes 0 and 3.
- Byte assembly: 3-bit bit counter. A byte completes on the 8th rising edge. CS high at any time clears the counter and returns to IDLE. A partial byte is discarded.
- FSM states and transitions:
  - IDLE: entered when CS goes high. Moves to CMD when CS goes low.
  - CMD: latches the opcode.
    - 03 (READ) and 02 (WRITE) go to ADDR_HI.
    - 05 (RDSR) goes to RDSR_OUT.
    - 01 (WRSR) goes to WRSR_IN.
    - 06 (WREN) sets WEL; 04 (WRDI) clears WEL; both then go to IGNORE.
    - Any other opcode goes to IGNORE and is not recorded in last_cmd.
  - ADDR_HI, then ADDR_LO: assemble the 16-bit address. The next state is READ_DATA or WRITE_DATA.
  - READ_DATA:
    - On the falling edge after the last address bit, load mem[addr] and drive its MSB.
    - After each 8 bits, addr increments modulo 2**ADDR_W (whole-array wrap).
  - WRITE_DATA:
    - Each completed byte is written to mem[addr] only if WEL=1 and addr is not protected.
    - addr[log2(PAGE_SIZE)-1:0] then increments, with wrap inside the page. Upper address bits do not change.
  - RDSR_OUT: shifts status_reg out repeatedly for as long as clocks continue.
  - WRSR_IN:
    - The first completed byte updates BP from bits [3:2], only if WEL=1.
    - Further bytes are ignored.
  - IGNORE: no action until CS goes high.
- Block protect, from BP:
  - 00: nothing protected
  - 01: upper quarter of the array protected
  - 10: upper half protected
  - 11: whole array protected
- WEL clear on CS deassertion: after WRITE or WRSR, WEL clears if at least one full data byte was received, even if the write was blocked. Otherwise WEL is unchanged.
- cmd_done and last_cmd update in the same clock as the synchronised CS rising edge.
- Simultaneous events:
  - A CS rise and an SCK edge seen in the same clock: the CS rise wins.
  - rst_n asserted mid-transaction aborts the transaction. No memory write occurs for an incomplete byte.
- Addresses above 2**ADDR_W-1 alias onto the low bits.

Decomposition:
- Shared package spi_eeprom_pkg holds:
  - the SPI_CMD_* opcode constants (shared with the bridge)
  - the state encoding
  - the status-bit indices
- Sub-module spi_slave_shifter: synchroniser, edge detect, bit counter, byte_valid pulse and MISO shift/load. The top level holds the FSM, status register and memory.

Test Plan:
- WREN; WRITE addr 0x0010, data A5 3C; CS high -> mem[0x10]=A5, mem[0x11]=3C; WEL=0; cmd_done pulse; last_cmd=02.
- READ 0x0010, three bytes -> MISO returns A5, 3C, FF; SPI_MISO_OE high only during the data phase.
- Write without WREN: WRITE 0x0020 data 11 -> mem[0x20] stays FF.
- WREN; WRITE 0x001E with 4 bytes 01 02 03 04 -> page wraps, so 0x1E=01, 0x1F=02, 0x10=03, 0x11=04.
- WREN; WRSR 0x0C; then WREN; WRITE 0x0000 data 55 -> protection blocks it, mem[0]=FF; RDSR returns 0x0C after the WRSR and 0x0E after the second WREN.
- READ 0x00FF two bytes -> returns mem[0xFF] then mem[0x00]. Separately, rst_n pulsed mid-address -> all outputs return to reset values and memory is unchanged apart from the reset fill.
